// File: rtl/gcd_pkg.sv
// Shared types, control-word field map and the subtractive-GCD microprogram
// for the GCD sequencer and its microcode ROM.
package gcd_pkg;

    localparam int UC_DEPTH = 32;

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_JMP  = 3'd1,
        OP_BZ   = 3'd2,
        OP_BNZ  = 3'd3,
        OP_FIN  = 3'd4
    } seq_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_ERROR
    } seq_state_t;

    typedef struct packed {
        seq_op_t     op;
        logic [4:0]  target;
        logic [15:0] cw;
    } uinstr_t;

    typedef uinstr_t [UC_DEPTH-1:0] ucode_t;

    localparam logic [4:0] ROM_START = 5'd1;

    // Datapath control-word fields; CW_ZS_* picks which condition drives zero_flag.
    localparam logic [15:0] CW_LD_A   = 16'h0001;
    localparam logic [15:0] CW_LD_B   = 16'h0002;
    localparam logic [15:0] CW_SUB_AB = 16'h0004;
    localparam logic [15:0] CW_SUB_BA = 16'h0008;
    localparam logic [15:0] CW_MOV_BA = 16'h0010;
    localparam logic [15:0] CW_ZS_A0  = 16'h0000;
    localparam logic [15:0] CW_ZS_B0  = 16'h0020;
    localparam logic [15:0] CW_ZS_EQ  = 16'h0040;
    localparam logic [15:0] CW_ZS_LT  = 16'h0060;

    function automatic uinstr_t uc_word(input seq_op_t op, input logic [4:0] tgt,
                                        input logic [15:0] cw);
        uinstr_t w;
        w.op     = op;
        w.target = tgt;
        w.cw     = cw;
        return w;
    endfunction

    // Result lands in A. Zero operands are handled before the subtract loop.
    function automatic ucode_t gcd_program();
        ucode_t u;
        for (int i = 0; i < UC_DEPTH; i++) u[i] = uc_word(OP_FIN, 5'd0, 16'h0000);
        u[1] = uc_word(OP_NEXT, 5'd0, CW_LD_A | CW_LD_B);
        u[2] = uc_word(OP_BZ,   5'd8, CW_ZS_A0);
        u[3] = uc_word(OP_BZ,   5'd9, CW_ZS_B0);
        u[4] = uc_word(OP_BZ,   5'd9, CW_ZS_EQ);
        u[5] = uc_word(OP_BZ,   5'd7, CW_ZS_LT);
        u[6] = uc_word(OP_JMP,  5'd4, CW_SUB_AB);
        u[7] = uc_word(OP_JMP,  5'd4, CW_SUB_BA);
        u[8] = uc_word(OP_JMP,  5'd9, CW_MOV_BA);
        u[9] = uc_word(OP_FIN,  5'd0, 16'h0000);
        return u;
    endfunction

    localparam ucode_t GCD_UCODE = gcd_program();

endpackage

// File: rtl/gcd_ucode_rom.sv
// Combinational microcode ROM; the program image is a parameter so other
// programs can be dropped in without touching the sequencer.
import gcd_pkg::*;

module gcd_ucode_rom #(
    parameter int     AW    = 5,
    parameter ucode_t UCODE = GCD_UCODE
) (
    input  logic [AW-1:0] addr,
    output uinstr_t       uinstr
);

    assign uinstr = UCODE[addr];

endmodule

// File: rtl/gcd_sequencer.sv
// Program-counter sequencer for the GCD engine: start/busy/done handshake,
// conditional branching on zero_flag and a per-run cycle watchdog.
import gcd_pkg::*;

module gcd_sequencer #(
    parameter int     MAX_CYCLES = 1023,
    parameter int     AW         = 5,
    parameter ucode_t UCODE      = GCD_UCODE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          zero_flag,
    output logic [15:0]   CW,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] pc
);

    localparam int             WD_W   = $clog2(MAX_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_CYCLES);

    seq_state_t    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    uinstr_t       ui;
    logic [AW-1:0] pc_inc, pc_next;
    logic [WD_W-1:0] wd_inc;
    logic          taken, illegal;

    gcd_ucode_rom #(.AW(AW), .UCODE(UCODE)) u_rom (
        .addr   (pc_q),
        .uinstr (ui)
    );

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (ui.op)
            OP_NEXT: taken = 1'b0;
            OP_JMP:  taken = 1'b1;
            OP_BZ:   taken = zero_flag;
            OP_BNZ:  taken = ~zero_flag;
            OP_FIN:  taken = 1'b0;
            default: illegal = 1'b1;
        endcase
        pc_inc  = pc_q + 1'b1;
        pc_next = taken ? AW'(ui.target) : pc_inc;
        wd_inc  = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wd_d    = wd_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = AW'(ROM_START);
                    wd_d    = '0;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                end
            end
            ST_RUN: begin
                wd_d = wd_inc;
                if (illegal) begin
                    state_d = ST_ERROR;
                    pc_d    = '0;
                    error_d = 1'b1;
                end else if (ui.op == OP_FIN) begin
                    state_d = ST_DONE;
                    pc_d    = '0;
                    done_d  = 1'b1;
                end else if (wd_inc == WD_MAX) begin
                    // wd_inc counts this cycle, so the run stops after exactly MAX_CYCLES
                    state_d = ST_ERROR;
                    pc_d    = '0;
                    error_d = 1'b1;
                end else begin
                    pc_d   = pc_next;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            wd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign CW    = (state_q == ST_RUN) ? ui.cw : 16'h0000;
    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;
    assign pc    = pc_q;

endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer: a directed microprogram driven by random zero_flag
// and start, plus the real GCD program against a small datapath model.
module tb_gcd_sequencer;
    import gcd_pkg::*;

    localparam int TMAX = 20;

    function automatic ucode_t test_program();
        ucode_t u;
        for (int i = 0; i < UC_DEPTH; i++) u[i] = uc_word(OP_FIN, 5'd0, 16'h0000);
        u[0]  = uc_word(OP_FIN,  5'd0,  16'h0100);
        u[1]  = uc_word(OP_BZ,   5'd6,  16'h0011);
        u[2]  = uc_word(OP_BNZ,  5'd10, 16'h0022);
        u[3]  = uc_word(OP_NEXT, 5'd0,  16'h0033);
        u[4]  = uc_word(OP_FIN,  5'd0,  16'h0044);
        u[6]  = uc_word(OP_BNZ,  5'd12, 16'h0066);
        u[7]  = uc_word(seq_op_t'(3'd6), 5'd0, 16'h0077);
        u[10] = uc_word(OP_JMP,  5'd10, 16'h00AA);
        u[12] = uc_word(OP_JMP,  5'd30, 16'h00CC);
        u[30] = uc_word(OP_NEXT, 5'd0,  16'h00EE);
        u[31] = uc_word(OP_NEXT, 5'd0,  16'h00FF);
        return u;
    endfunction

    localparam ucode_t TEST_UCODE = test_program();

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, zero_flag = 1'b0;
    logic [15:0] cw;
    logic        busy, done, error;
    logic [4:0]  pc;
    logic        e_start = 1'b0, e_zf;
    logic [15:0] e_cw;
    logic        e_busy, e_done, e_err;
    logic [4:0]  e_pc;
    logic [15:0] dp_a, dp_b, din_a = '0, din_b = '0;

    int checks = 0;
    int errors = 0;
    int mdl_pcs[$];
    bit mdl_err;
    bit err_exp = 1'b0;

    always #5 clk = ~clk;

    gcd_sequencer #(.MAX_CYCLES(TMAX), .AW(5), .UCODE(TEST_UCODE)) u_dut (
        .clk(clk), .reset(reset), .start(start), .zero_flag(zero_flag),
        .CW(cw), .busy(busy), .done(done), .error(error), .pc(pc)
    );

    gcd_sequencer u_e2e (
        .clk(clk), .reset(reset), .start(e_start), .zero_flag(e_zf),
        .CW(e_cw), .busy(e_busy), .done(e_done), .error(e_err), .pc(e_pc)
    );

    // Minimal datapath: two registers, subtract/move ops, selectable status flag.
    always_comb begin
        case (e_cw[6:5])
            2'd0:    e_zf = (dp_a == 16'd0);
            2'd1:    e_zf = (dp_b == 16'd0);
            2'd2:    e_zf = (dp_a == dp_b);
            default: e_zf = (dp_a < dp_b);
        endcase
    end

    always @(posedge clk) begin
        if (|(e_cw & CW_LD_A))   dp_a <= din_a;
        if (|(e_cw & CW_LD_B))   dp_b <= din_b;
        if (|(e_cw & CW_SUB_AB)) dp_a <= dp_a - dp_b;
        if (|(e_cw & CW_SUB_BA)) dp_b <= dp_b - dp_a;
        if (|(e_cw & CW_MOV_BA)) dp_a <= dp_b;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic rz();
        return 1'($urandom & 1);
    endfunction

    function automatic int gcd_ref(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Interprets the test program: list of addresses visited in RUN and how the run ends.
    task automatic model_run(input logic [63:0] zfv);
        int p;
        int n;
        bit fin;
        uinstr_t w;
        mdl_pcs.delete();
        p   = int'(ROM_START);
        n   = 0;
        fin = 1'b0;
        while (!fin) begin
            mdl_pcs.push_back(p);
            w = TEST_UCODE[p];
            n++;
            if (int'(w.op) > 4) begin
                mdl_err = 1'b1; fin = 1'b1;
            end else if (w.op == OP_FIN) begin
                mdl_err = 1'b0; fin = 1'b1;
            end else begin
                if (w.op == OP_JMP || (w.op == OP_BZ && zfv[n-1]) || (w.op == OP_BNZ && !zfv[n-1]))
                    p = int'(w.target);
                else
                    p = (p + 1) % UC_DEPTH;
                if (n == TMAX) begin
                    mdl_err = 1'b1; fin = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic st, input logic zf, input logic [15:0] ecw, input logic eb,
                        input logic ed, input logic ee, input int epc, input bit cpc);
        @(negedge clk);
        start     = st;
        zero_flag = zf;
        #1;
        chk("cw", 32'(cw), 32'(ecw));
        chk("busy", 32'(busy), 32'(eb));
        chk("done", 32'(done), 32'(ed));
        chk("error", 32'(error), 32'(ee));
        if (cpc) chk("pc", 32'(pc), 32'(epc));
    endtask

    task automatic do_run(input int k, input logic [63:0] zfv, input bit hold);
        model_run(zfv);
        for (int i = 0; i < k; i++) step(1'b0, rz(), 16'h0, 1'b0, 1'b0, err_exp, 0, 1'b1);
        step(1'b1, rz(), 16'h0, 1'b0, 1'b0, err_exp, 0, 1'b1);
        for (int i = 0; i < mdl_pcs.size(); i++)
            step(hold ? 1'b1 : rz(), zfv[i], TEST_UCODE[mdl_pcs[i]].cw, 1'b1, 1'b0, 1'b0,
                 mdl_pcs[i], 1'b1);
        err_exp = mdl_err;
        step(hold ? 1'b1 : rz(), rz(), 16'h0, 1'b0, !mdl_err, mdl_err, 0, 1'b0);
    endtask

    task automatic e2e(input int a, input int b);
        int c;
        @(negedge clk);
        din_a   = 16'(a);
        din_b   = 16'(b);
        e_start = 1'b1;
        @(negedge clk);
        e_start = 1'b0;
        c = 0;
        while (!e_done && !e_err && c < 1100) begin
            @(negedge clk);
            c++;
        end
        chk("e2e_done", 32'(e_done), 32'd1);
        chk("e2e_err", 32'(e_err), 32'd0);
        chk("e2e_busy", 32'(e_busy), 32'd0);
        chk("e2e_pc", 32'(e_pc), 32'd0);
        chk("e2e_gcd", 32'(dp_a), 32'(gcd_ref(a, b)));
    endtask

    initial begin
        #12;
        chk("rst_cw", 32'(cw), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("rst_e2e", {e_cw, 11'd0, e_pc, e_busy, e_done, e_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Hand-derived traces of the test program pin the model.
        model_run(64'b10);
        chk("pin_lin_len", 32'(mdl_pcs.size()), 32'd4);
        chk("pin_lin_last", 32'(mdl_pcs[3]), 32'd4);
        chk("pin_lin_err", 32'(mdl_err), 32'd0);
        model_run(64'b11);
        chk("pin_ill_len", 32'(mdl_pcs.size()), 32'd3);
        chk("pin_ill_pc", 32'(mdl_pcs[2]), 32'd7);
        chk("pin_ill_err", 32'(mdl_err), 32'd1);
        model_run(64'b01);
        chk("pin_wrap_len", 32'(mdl_pcs.size()), 32'd6);
        chk("pin_wrap_last", 32'(mdl_pcs[5]), 32'd0);
        model_run(64'b00);
        chk("pin_wd_len", 32'(mdl_pcs.size()), 32'd20);
        chk("pin_wd_pc", 32'(mdl_pcs[19]), 32'd10);
        chk("pin_wd_err", 32'(mdl_err), 32'd1);

        // Linear, both branch directions, wrap, watchdog, then error cleared by next start.
        do_run(1, 64'b10, 1'b0);
        do_run(0, 64'b11, 1'b0);
        do_run(2, 64'b01, 1'b0);
        do_run(1, 64'b00, 1'b0);
        do_run(1, 64'b10, 1'b0);
        do_run(0, 64'b11, 1'b1);
        do_run(0, 64'b10, 1'b1);
        do_run(0, 64'b00, 1'b1);
        do_run(0, 64'b01, 1'b1);

        // Asynchronous reset while sitting on pc 7.
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, err_exp, 0, 1'b1);
        step(1'b0, 1'b1, 16'h0011, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        step(1'b0, 1'b1, 16'h0066, 1'b1, 1'b0, 1'b0, 6, 1'b1);
        @(negedge clk);
        #1;
        chk("pre_rst_pc", 32'(pc), 32'd7);
        chk("pre_rst_cw", 32'(cw), 32'h77);
        reset = 1'b0;
        #1;
        chk("mid_rst_cw", 32'(cw), 32'd0);
        chk("mid_rst_pc", 32'(pc), 32'd0);
        chk("mid_rst_flags", {29'd0, busy, done, error}, 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        err_exp = 1'b0;
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1);

        for (int r = 0; r < 40; r++)
            do_run(int'($urandom_range(0, 2)), {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0));

        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, err_exp, 0, 1'b1);

        e2e(48, 18);
        e2e(17, 17);
        e2e(0, 5);
        e2e(5, 0);
        e2e(0, 0);
        for (int r = 0; r < 6; r++) e2e(int'($urandom_range(1, 100)), int'($urandom_range(1, 100)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_sequencer.md
# gcd_sequencer

Microcoded controller for the GCD engine. It drives the 16-bit control word into `gcd_datapath` every cycle and branches on the datapath's `zero_flag`. It also provides a start/busy/done handshake to the host. The algorithm lives entirely in a microcode ROM, so this block is a generic program-counter sequencer with conditional branching and a cycle watchdog.

## Interface
Parameters:
- `MAX_CYCLES`, default 1023: watchdog limit, counted in cycles per run.
- `AW`, default 5: microcode address width (32 words).

Ports:
- `clk`  input  1: single clock.
- `reset`  input  1: asynchronous, active-low reset.
- `start`  input  1: host request to begin a run. Sampled only in IDLE.
- `zero_flag`  input  1: status from `gcd_datapath`. Combinational with the current `CW`.
- `CW`  output  16: control word to `gcd_datapath`.
- `busy`  output  1: high from the first cycle of a run until DONE or ERROR.
- `done`  output  1: one-cycle pulse when the run completes normally.
- `error`  output  1: sticky watchdog flag. Cleared by the next accepted `start` or by reset.
- `pc`  output  AW: current micro-address, for debug and verification.

## Operation
Microinstruction word is 24 bits:
- [15:0] `cw`: control word.
- [15+AW:16] `target`: branch target address.
- [23:21] `op`: sequencing operation.

Ops (`seq_op_t`):
- NEXT = 0: go to pc+1.
- JMP = 1: go to `target`.
- BZ = 2: go to `target` if `zero_flag`=1, else pc+1.
- BNZ = 3: go to `target` if `zero_flag`=0, else pc+1.
- FIN = 4: end the run.
- Codes 5–7: illegal, treated as FIN plus `error`.

Controller states (`seq_state_t`): IDLE, RUN, DONE, ERROR.
- **IDLE**
  - `pc`=0, `CW`=0, `busy`=0.
  - When `start`=1: go to RUN, set `pc`=ROM_START (package constant, 1), clear `error`.
- **RUN**
  - `CW` = ROM[`pc`].cw.
  - Next `pc` follows `op`, evaluated with this cycle's `zero_flag`.
  - FIN: go to DONE. The FIN word's `cw` is still driven during its cycle.
  - Watchdog counter reaches `MAX_CYCLES`: go to ERROR.
  - Illegal op: go to ERROR.
- **DONE**
  - `done`=1 for exactly this cycle, `CW`=0, `busy`=0.
  - Go to IDLE next cycle.
- **ERROR**
  - `error` is set, `CW`=0, `busy`=0.
  - Go to IDLE next cycle. `error` stays high.

Arithmetic rules:
- `pc`+1 wraps modulo 2^AW.
- A wrap from the last address to 0 while in RUN is legal. Address 0 is a normal word in RUN.
- The watchdog counter is $clog2(MAX_CYCLES+1) bits wide.
  - It clears on entry to RUN and increments on every RUN cycle.
  - It saturates, and never wraps.

Boundary conditions:
- `start` held high during RUN, DONE or ERROR is ignored. A held `start` re-triggers on the first IDLE cycle.
- A branch whose `target` equals `pc` is legal. Only the watchdog terminates such a loop.
- Reset asserted mid-run: immediately IDLE, `pc`=0, `CW`=0, all flags 0.
- A `zero_flag` change within a cycle affects only that cycle's branch decision.

## Timing
- Reset values of all outputs are 0: `CW`, `busy`, `done`, `error`, `pc`.
- Start latency: `start` sampled high at edge N gives the first microinstruction's `CW` in cycle N+1, with `busy`=1.
- `pc`, state and the watchdog are registered.
- `CW` is combinational from registered `pc` and state. There is no extra pipeline stage: a branch decision takes effect at the next edge.
- Run length is the number of RUN cycles. `done` rises one cycle after the FIN cycle.
- Watchdog: the run is aborted after `MAX_CYCLES` RUN cycles. `error` rises in the following cycle.

## Structure
- `gcd_pkg` holds:
  - `seq_op_t`
  - `seq_state_t`
  - `uinstr_t` (packed struct: `op`, `target`, `cw`)
  - `ROM_START`
  - the `GCD_UCODE` constant array.
- `GCD_UCODE` is the subtractive-GCD program. It is owned by whoever owns the datapath's `CW` field map.
- Sub-module `gcd_ucode_rom`: combinational, `addr` in, `uinstr_t` out, indexing `GCD_UCODE`. The testbench swaps it in for directed programs.
- `gcd_sequencer` contains the state register, `pc`, the watchdog and the branch logic.

## Test plan
1. **Reset:** reset low mid-RUN at `pc`=7 → same-cycle `CW`=0 and `pc`=0. After release, IDLE with `busy`=0 and `error`=0.
2. **Linear program:** ROM words 1–3 are NEXT with `cw`=16'h0011, 16'h0022, 16'h0033, and word 4 is FIN with `cw`=16'h0044. Pulse `start` → `CW` sequence 11, 22, 33, 44 in cycles 1–4, `done` pulse in cycle 5, `busy` high for exactly 4 cycles.
3. **Branching:** word 1 is BZ `target`=6 with `zero_flag` forced 1 → `pc` goes 1→6. Repeat with `zero_flag`=0 → `pc` goes 1→2. Repeat both with BNZ → opposite results.
4. **Watchdog:** word 1 is JMP to 1 with `MAX_CYCLES`=20 → `busy` for 20 cycles, then `error`=1 and `done`=0. The next `start` clears `error`.
5. **Illegal op and start handling:** op=6 at word 2 → ERROR after 2 RUN cycles. `start` held high throughout → a new run begins on the first IDLE cycle. A `start` pulse during RUN is ignored.
6. **End-to-end:** with `gcd_datapath` connected, load 48 and 18 → `done` asserted and `data_out`=6. Load 17 and 17 → 17. Load 0 and 5 → 5 within `MAX_CYCLES`.
